// File: rtl/mips_mem_arb_pkg.sv
// ============================================================================
// Module  : mips_mem_arb_pkg
// Purpose : Shared types and constants for the MIPS memory-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mem_arb_pkg;

   // Transfer sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      ACK  = 2'd2
   } arb_state_t;

   // Owner of the current or most recent bus transfer
   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   // Byte enables used for every fetch; sliced to DW/8 at the point of use
   localparam logic [63:0] BE_ALL = '1;

endpackage : mips_mem_arb_pkg

`default_nettype wire

// File: rtl/mips_mem_arb_pick.sv
// ============================================================================
// Module  : mips_mem_arb_pick
// Purpose : Combinational grant select between fetch (I) and data (D).
//           MEM_ARB_RR_EN defined   : round-robin on simultaneous requests.
//           MEM_ARB_RR_EN undefined : fixed priority, D beats I.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mem_arb_pick
   import mips_mem_arb_pkg::*;
(
   input  logic   i_req_i,
   input  logic   d_req_i,
   input  owner_t last_i,
   output owner_t grant_o
);

`ifdef MEM_ARB_RR_EN
   // Lone request wins outright; on a tie the side not granted last wins
   always_comb begin
      grant_o = OWN_I;
      if (i_req_i && d_req_i) begin
         grant_o = (last_i == OWN_D) ? OWN_I : OWN_D;
      end else if (d_req_i) begin
         grant_o = OWN_D;
      end
   end
`else
   logic unused_last;
   assign unused_last = last_i;

   // D belongs to the older instruction, so it always wins a tie
   always_comb begin
      grant_o = OWN_I;
      if (d_req_i) begin
         grant_o = OWN_D;
      end
   end
`endif

endmodule : mips_mem_arb_pick

`default_nettype wire

// File: rtl/mips_mem_arbiter.sv
// ============================================================================
// Module  : mips_mem_arbiter
// Purpose : Shares one Avalon-MM master port between instruction fetch and
//           data load/store. One transfer at a time: IDLE -> BUS -> ACK.
//           Arbitration mode selected by MEM_ARB_RR_EN (see mips_mem_arb_pick).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mem_arbiter
   import mips_mem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   // Instruction fetch side
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_ack,
   output logic [DW-1:0]   i_rdata,
   // Data load/store side
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic            d_ack,
   output logic [DW-1:0]   d_rdata,
   // Avalon-MM master
   output logic [AW-1:0]   avm_address,
   output logic            avm_read,
   output logic            avm_write,
   output logic [DW-1:0]   avm_writedata,
   output logic [DW/8-1:0] avm_byteenable,
   input  logic            avm_waitrequest,
   input  logic [DW-1:0]   avm_readdata,
   // Status
   output logic            busy
);

   arb_state_t      state_q;
   owner_t          owner_q;
   owner_t          last_q;
   owner_t          grant_d;

   logic            i_ack_q;
   logic            d_ack_q;
   logic [DW-1:0]   i_rdata_q;
   logic [DW-1:0]   d_rdata_q;
   logic [AW-1:0]   avm_address_q;
   logic            avm_read_q;
   logic            avm_write_q;
   logic [DW-1:0]   avm_writedata_q;
   logic [DW/8-1:0] avm_byteenable_q;

   mips_mem_arb_pick u_pick (
      .i_req_i (i_req),
      .d_req_i (d_req),
      .last_i  (last_q),
      .grant_o (grant_d)
   );

   // Transfer sequencer: capture the winner in IDLE, hold the bus through
   // stalls, then pulse the owner's ack for a single cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= IDLE;
         owner_q          <= OWN_I;
         last_q           <= OWN_D;
         i_ack_q          <= 1'b0;
         d_ack_q          <= 1'b0;
         i_rdata_q        <= '0;
         d_rdata_q        <= '0;
         avm_address_q    <= '0;
         avm_read_q       <= 1'b0;
         avm_write_q      <= 1'b0;
         avm_writedata_q  <= '0;
         avm_byteenable_q <= '0;
      end else begin
         i_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_req || d_req) begin
                  owner_q <= grant_d;
                  last_q  <= grant_d;
                  state_q <= BUS;
                  if (grant_d == OWN_D) begin
                     avm_address_q    <= d_addr;
                     avm_writedata_q  <= d_wdata;
                     avm_byteenable_q <= d_be;
                     avm_read_q       <= ~d_we;
                     avm_write_q      <= d_we;
                  end else begin
                     avm_address_q    <= i_addr;
                     avm_writedata_q  <= '0;
                     avm_byteenable_q <= BE_ALL[DW/8-1:0];
                     avm_read_q       <= 1'b1;
                     avm_write_q      <= 1'b0;
                  end
               end
            end
            BUS: begin
               if (!avm_waitrequest) begin
                  if (avm_read_q) begin
                     if (owner_q == OWN_D) begin
                        d_rdata_q <= avm_readdata;
                     end else begin
                        i_rdata_q <= avm_readdata;
                     end
                  end
                  avm_read_q  <= 1'b0;
                  avm_write_q <= 1'b0;
                  state_q     <= ACK;
                  if (owner_q == OWN_D) begin
                     d_ack_q <= 1'b1;
                  end else begin
                     i_ack_q <= 1'b1;
                  end
               end
            end
            ACK: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign i_ack          = i_ack_q;
   assign d_ack          = d_ack_q;
   assign i_rdata        = i_rdata_q;
   assign d_rdata        = d_rdata_q;
   assign avm_address    = avm_address_q;
   assign avm_read       = avm_read_q;
   assign avm_write      = avm_write_q;
   assign avm_writedata  = avm_writedata_q;
   assign avm_byteenable = avm_byteenable_q;
   assign busy           = (state_q != IDLE);

endmodule : mips_mem_arbiter

`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
// ============================================================================
// Module  : tb_mips_mem_arbiter
// Purpose : Self-checking bench for mips_mem_arbiter. A transaction-level
//           reference model is compared against every output each cycle,
//           and directed scenarios pin latencies, ordering and data values.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_be = '0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest = 1'b0;
   logic [31:0] avm_readdata;
   logic        busy;

   int checks = 0;
   int errors = 0;

   mips_mem_arbiter #(.AW(32), .DW(32)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .i_req           (i_req),
      .i_addr          (i_addr),
      .i_ack           (i_ack),
      .i_rdata         (i_rdata),
      .d_req           (d_req),
      .d_we            (d_we),
      .d_addr          (d_addr),
      .d_wdata         (d_wdata),
      .d_be            (d_be),
      .d_ack           (d_ack),
      .d_rdata         (d_rdata),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // Memory contents seen by the bus
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h0000_0040) return 32'h2402_0005;
      return {~a[15:0], a[15:0]};
   endfunction

   assign avm_readdata = mem_val(avm_address);

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- bus responder: waitrequest for wait_cfg cycles -------
   int wait_cfg = 0;
   int wait_left = 0;
   always @(negedge clk) begin
      if (avm_read || avm_write) begin
         if (wait_left > 0) begin
            avm_waitrequest = 1'b1;
            wait_left--;
         end else begin
            avm_waitrequest = 1'b0;
         end
      end else begin
         avm_waitrequest = 1'b0;
         wait_left = wait_cfg;
      end
   end

   // ---------------- reference model (transaction level) ------------------
   typedef struct packed {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } txn_t;

   function automatic logic pick_d(input logic ir, input logic dr, input logic lastd);
`ifdef MEM_ARB_RR_EN
      if (ir && dr) return ~lastd;
`endif
      return dr;
   endfunction

   function automatic txn_t make_txn(input logic g_d, input logic we, input logic [31:0] da,
                                     input logic [31:0] wd, input logic [3:0] be,
                                     input logic [31:0] ia);
      txn_t t;
      t.is_d  = g_d;
      t.we    = g_d ? we : 1'b0;
      t.addr  = g_d ? da : ia;
      t.wdata = g_d ? wd : 32'h0;
      t.be    = g_d ? be : 4'hF;
      return t;
   endfunction

   txn_t        m_t;
   logic        m_on_bus;
   logic        m_done;
   logic        m_last_d;
   logic [31:0] m_irdata;
   logic [31:0] m_drdata;

   // Model advances one transfer step per clock; async reset like the spec
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_t      <= '0;
         m_on_bus <= 1'b0;
         m_done   <= 1'b0;
         m_last_d <= 1'b1;
         m_irdata <= '0;
         m_drdata <= '0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_on_bus) begin
         if (!avm_waitrequest) begin
            m_on_bus <= 1'b0;
            m_done   <= 1'b1;
            if (!m_t.we && m_t.is_d)  m_drdata <= mem_val(m_t.addr);
            if (!m_t.we && !m_t.is_d) m_irdata <= mem_val(m_t.addr);
         end
      end else if (i_req || d_req) begin
         m_t      <= make_txn(pick_d(i_req, d_req, m_last_d), d_we, d_addr, d_wdata, d_be, i_addr);
         m_last_d <= pick_d(i_req, d_req, m_last_d);
         m_on_bus <= 1'b1;
      end
   end

   // ---------------- compare process + simple monitors --------------------
   logic cmp_en = 1'b0;
   int   rd_hi_cnt = 0;
   int   wr_hi_cnt = 0;
   int   busy_lo_cnt = 0;
   int   wr_unstable = 0;

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("avm_read",  {31'b0, avm_read},  {31'b0, m_on_bus && !m_t.we});
         chk("avm_write", {31'b0, avm_write}, {31'b0, m_on_bus && m_t.we});
         chk("i_ack",     {31'b0, i_ack},     {31'b0, m_done && !m_t.is_d});
         chk("d_ack",     {31'b0, d_ack},     {31'b0, m_done && m_t.is_d});
         chk("busy",      {31'b0, busy},      {31'b0, m_on_bus || m_done});
         chk("i_rdata",   i_rdata, m_irdata);
         chk("d_rdata",   d_rdata, m_drdata);
         if (m_on_bus) begin
            chk("avm_address",    avm_address, m_t.addr);
            chk("avm_byteenable", {28'b0, avm_byteenable}, {28'b0, m_t.be});
            if (m_t.we) chk("avm_writedata", avm_writedata, m_t.wdata);
         end
      end
      if (avm_read)  rd_hi_cnt++;
      if (avm_write) begin
         wr_hi_cnt++;
         if (avm_address != 32'h100 || avm_writedata != 32'hDEAD_BEEF || avm_byteenable != 4'b0011)
            wr_unstable++;
      end
      if (!busy) busy_lo_cnt++;
   end

   // Wait (bounded) for an ack; n = negedges from call to ack
   task automatic wait_ack(input bit want_d, input int maxc, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(want_d ? d_ack : i_ack) && n < maxc);
      if (!(want_d ? d_ack : i_ack)) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   // ---------------- directed stimulus ------------------------------------
   int n;
   int t_i, t_d, t_a;
   int ord[4];
   int k;

   initial begin
      @(posedge clk);
      #1 cmp_en = 1'b1;
      chk("rst_avm_address", avm_address, 32'h0);
      chk("rst_strobes", {30'b0, avm_read, avm_write}, 32'h0);
      chk("rst_byteenable", {28'b0, avm_byteenable}, 32'h0);
      chk("rst_acks_busy", {29'b0, i_ack, d_ack, busy}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // 1) single fetch, no wait
      @(negedge clk);
      rd_hi_cnt = 0;
      wait_cfg = 0;
      i_addr = 32'h0000_0040;
      i_req = 1'b1;
      wait_ack(1'b0, 10, n);
      i_req = 1'b0;
      chk("fetch_latency", n, 2);
      chk("fetch_read_cycles", rd_hi_cnt, 1);
      chk("fetch_rdata", i_rdata, 32'h2402_0005);

      // 2) data write with 3 wait cycles
      @(negedge clk);
      wr_hi_cnt = 0;
      wr_unstable = 0;
      wait_cfg = 3;
      d_we = 1'b1;
      d_addr = 32'h100;
      d_wdata = 32'hDEAD_BEEF;
      d_be = 4'b0011;
      d_req = 1'b1;
      wait_ack(1'b1, 20, n);
      d_req = 1'b0;
      d_we = 1'b0;
      chk("write_latency", n, 5);
      chk("write_hold_cycles", wr_hi_cnt, 4);
      chk("write_bus_stable", wr_unstable, 0);
      chk("write_d_rdata_unchanged", d_rdata, 32'h0);

      // 3) simultaneous fetch + load (last grant was D)
      @(negedge clk);
      wait_cfg = 0;
      i_addr = 32'h8;
      d_addr = 32'h200;
      i_req = 1'b1;
      d_req = 1'b1;
      t_i = -1;
      t_d = -1;
      for (int c = 1; c <= 20 && (t_i < 0 || t_d < 0); c++) begin
         @(negedge clk);
         if (d_ack) begin t_d = c; d_req = 1'b0; end
         if (i_ack) begin t_i = c; i_req = 1'b0; end
      end
      i_req = 1'b0;
      d_req = 1'b0;
`ifdef MEM_ARB_RR_EN
      chk("sim_first_ack", t_i, 2);
      chk("sim_second_gap", t_d - t_i, 3);
`else
      chk("sim_first_ack", t_d, 2);
      chk("sim_second_gap", t_i - t_d, 3);
`endif
      chk("sim_d_rdata", d_rdata, 32'hFDFF_0200);
      chk("sim_i_rdata", i_rdata, 32'hFFF7_0008);

      // 4) both held for 4 transfers, after a fetch so last = I
      @(negedge clk);
      i_addr = 32'h10;
      i_req = 1'b1;
      wait_ack(1'b0, 10, n);
      i_req = 1'b0;
      @(negedge clk);
      i_addr = 32'h20;
      d_addr = 32'h300;
      i_req = 1'b1;
      d_req = 1'b1;
      k = 0;
      for (int c = 0; c < 40 && k < 4; c++) begin
         @(negedge clk);
         if (d_ack) begin ord[k] = 1; k++; end
         else if (i_ack) begin ord[k] = 0; k++; end
      end
      i_req = 1'b0;
      d_req = 1'b0;
      chk("order_count", k, 4);
      for (int j = 0; j < 4; j++) begin
`ifdef MEM_ARB_RR_EN
         chk("rr_order", ord[j], (j % 2 == 0) ? 1 : 0);
`else
         chk("fixed_order", ord[j], 1);
`endif
      end

      // 5) reset during a stalled fetch
      @(negedge clk);
      @(negedge clk);
      wait_cfg = 10;
      i_addr = 32'h44;
      i_req = 1'b1;
      n = 0;
      while (!avm_read && n < 5) begin @(negedge clk); n++; end
      chk("rst_mid_strobe_seen", {31'b0, avm_read}, 32'd1);
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1 chk("rst_mid_strobes_drop", {30'b0, avm_read, avm_write}, 32'h0);
      chk("rst_mid_no_ack", {30'b0, i_ack, d_ack}, 32'h0);
      wait_cfg = 0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      wait_ack(1'b0, 10, n);
      i_req = 1'b0;
      chk("rst_mid_reservice_latency", n, 2);
      chk("rst_mid_rdata", i_rdata, 32'hFFBB_0044);

      // 6) back-to-back fetches at 0x0, 0x4, 0x8
      @(negedge clk);
      @(negedge clk);
      i_addr = 32'h0;
      i_req = 1'b1;
      t_a = 0;
      wait_ack(1'b0, 10, n);
      busy_lo_cnt = 0;
      i_addr = 32'h4;
      for (int j = 0; j < 2; j++) begin
         wait_ack(1'b0, 10, n);
         chk("b2b_ack_spacing", n, 3);
         i_addr = 32'h8;
      end
      i_req = 1'b0;
      chk("b2b_busy_low_cycles", busy_lo_cnt, 2);
      chk("b2b_last_rdata", i_rdata, 32'hFFF7_0008);

      @(negedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time bound so the run always ends
   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_mips_mem_arbiter

`default_nettype wire
